// File: rtl/strip_alloc_ctrl.sv
// rtl/strip_alloc_ctrl.sv - first-fit strip allocator with round-robin request arbitration
module strip_alloc_ctrl #(
   parameter int NUM_STRIPS   = 16,
   parameter int STRIP_WIDTH  = 200,
   parameter int STRIKE_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_width,
   input  logic       req1_valid,
   input  logic [7:0] req1_width,
   output logic       req0_ready,
   output logic       req1_ready,
   input  logic       clr,
   output logic       wr_valid,
   output logic [3:0] strip_ID_out,
   output logic [7:0] occupied_width_out,
   output logic [3:0] strike_out,
   output logic       resp_valid,
   output logic       resp_src,
   output logic       resp_ok,
   output logic [3:0] resp_strip_ID
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_FAIL  = 2'd3;

   localparam logic [3:0] LAST_IDX = 4'(NUM_STRIPS - 1);
   localparam logic [3:0] LIMIT    = 4'(STRIKE_LIMIT);
   localparam logic [8:0] CAP      = 9'(STRIP_WIDTH);

   logic [1:0] state_q, state_d;
   logic [3:0] idx_q, idx_d;
   // acc_q marks the IDLE cycle in which ready is pulsed; the width check follows it
   logic       acc_q;
   logic       pri_q;
   logic       src_q;
   logic [7:0] width_q;
   logic [7:0] occ_q    [NUM_STRIPS];
   logic [3:0] strike_q [NUM_STRIPS];

   logic [7:0] cur_occ;
   logic [3:0] cur_strike;
   logic [8:0] sum;
   logic       retired;
   logic       fit;
   logic       width_bad;
   logic       grant_any;
   logic       grant_sel;

   // Per-strip fit test and arbitration decode
   always_comb begin
      cur_occ    = occ_q[idx_q];
      cur_strike = strike_q[idx_q];
      sum        = {1'b0, cur_occ} + {1'b0, width_q};
      retired    = (cur_strike == LIMIT);
      fit        = !retired && (sum <= CAP);
      width_bad  = (width_q == 8'd0) || ({1'b0, width_q} > CAP);
      grant_any  = req0_valid || req1_valid;
      grant_sel  = (req0_valid && req1_valid) ? pri_q : req1_valid;
   end

   // FSM next state and scan index
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (acc_q) begin
               idx_d   = 4'd0;
               state_d = width_bad ? S_FAIL : S_SCAN;
            end
         end
         S_SCAN: begin
            if (fit) begin
               state_d = S_WRITE;
            end else if (idx_q == LAST_IDX) begin
               state_d = S_FAIL;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, table and registered output updates
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= S_IDLE;
         idx_q              <= 4'd0;
         acc_q              <= 1'b0;
         pri_q              <= 1'b0;
         src_q              <= 1'b0;
         width_q            <= 8'd0;
         req0_ready         <= 1'b0;
         req1_ready         <= 1'b0;
         wr_valid           <= 1'b0;
         strip_ID_out       <= 4'd0;
         occupied_width_out <= 8'd0;
         strike_out         <= 4'd0;
         resp_valid         <= 1'b0;
         resp_src           <= 1'b0;
         resp_ok            <= 1'b0;
         resp_strip_ID      <= 4'd0;
         for (int i = 0; i < NUM_STRIPS; i++) begin
            occ_q[i]    <= 8'd0;
            strike_q[i] <= 4'd0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= 1'b0;
         req0_ready <= 1'b0;
         req1_ready <= 1'b0;
         wr_valid   <= 1'b0;
         resp_valid <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (acc_q) begin
                  if (width_bad) begin
                     resp_valid    <= 1'b1;
                     resp_ok       <= 1'b0;
                     resp_strip_ID <= 4'hF;
                     resp_src      <= src_q;
                  end
               end else if (clr) begin
                  for (int i = 0; i < NUM_STRIPS; i++) begin
                     occ_q[i]    <= 8'd0;
                     strike_q[i] <= 4'd0;
                  end
               end else if (grant_any) begin
                  acc_q      <= 1'b1;
                  src_q      <= grant_sel;
                  width_q    <= grant_sel ? req1_width : req0_width;
                  pri_q      <= ~grant_sel;
                  req0_ready <= ~grant_sel;
                  req1_ready <= grant_sel;
               end
            end
            S_SCAN: begin
               if (fit) begin
                  occ_q[idx_q]       <= sum[7:0];
                  wr_valid           <= 1'b1;
                  strip_ID_out       <= idx_q;
                  occupied_width_out <= sum[7:0];
                  strike_out         <= cur_strike;
                  resp_valid         <= 1'b1;
                  resp_ok            <= 1'b1;
                  resp_strip_ID      <= idx_q;
                  resp_src           <= src_q;
               end else begin
                  if (!retired) begin
                     strike_q[idx_q] <= (cur_strike < LIMIT) ? cur_strike + 4'd1 : LIMIT;
                  end
                  if (idx_q == LAST_IDX) begin
                     resp_valid    <= 1'b1;
                     resp_ok       <= 1'b0;
                     resp_strip_ID <= 4'hF;
                     resp_src      <= src_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_strip_alloc_ctrl.sv
// tb/tb_strip_alloc_ctrl.sv - directed scoreboard bench for strip_alloc_ctrl
module tb_strip_alloc_ctrl;

   localparam int NS  = 16;
   localparam int CAP = 200;
   localparam int LIM = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_width, req1_width;
   logic       req0_ready, req1_ready;
   logic       clr;
   logic       wr_valid;
   logic [3:0] strip_ID_out;
   logic [7:0] occupied_width_out;
   logic [3:0] strike_out;
   logic       resp_valid, resp_src, resp_ok;
   logic [3:0] resp_strip_ID;

   strip_alloc_ctrl dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_width(req0_width),
      .req1_valid(req1_valid), .req1_width(req1_width),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .clr(clr), .wr_valid(wr_valid),
      .strip_ID_out(strip_ID_out), .occupied_width_out(occupied_width_out),
      .strike_out(strike_out), .resp_valid(resp_valid), .resp_src(resp_src),
      .resp_ok(resp_ok), .resp_strip_ID(resp_strip_ID)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         ok;
      bit         src;
      logic [3:0] strip;
      logic [7:0] occ;
      logic [3:0] strike;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   occ_m    [NS];
   int   strike_m [NS];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         occ_m[i]    = 0;
         strike_m[i] = 0;
      end
   endtask

   // First-fit reference: retired strips skipped, misses add a saturating strike
   task automatic push_exp(input bit src, input int w);
      exp_t e;
      e.src = src; e.ok = 0; e.strip = 4'hF; e.occ = 0; e.strike = 0; e.lat = 1;
      if (w != 0 && w <= CAP) begin
         e.lat = 1 + NS;
         for (int i = 0; i < NS; i++) begin
            if (strike_m[i] == LIM) continue;
            if (occ_m[i] + w <= CAP) begin
               occ_m[i] += w;
               e.ok = 1; e.strip = 4'(i); e.occ = 8'(occ_m[i]);
               e.strike = 4'(strike_m[i]); e.lat = 2 + i;
               break;
            end
            if (strike_m[i] < LIM) strike_m[i]++;
         end
      end
      sb.push_back(e);
   endtask

   task automatic wait_ready(input bit who, output int t);
      bit got = 0;
      t = 0;
      for (int n = 0; n < 60 && !got; n++) begin
         @(negedge clk);
         if ((who ? req1_ready : req0_ready) === 1'b1) begin
            got = 1;
            t = cyc;
            if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
         end
      end
      if (!got) begin
         vectors++; miscompares++;
         $error("FAIL ready_timeout: observed none expected ready%0d", who);
         req0_valid = 1'b0; req1_valid = 1'b0;
      end
   endtask

   task automatic wait_resp(input int t);
      bit   got = 0;
      exp_t e;
      for (int n = 0; n < 60 && !got; n++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) got = 1;
      end
      if (sb.size() == 0) begin
         vectors++; miscompares++;
         $error("FAIL scoreboard_empty: observed response expected none");
         return;
      end
      e = sb.pop_front();
      if (!got) begin
         vectors++; miscompares++;
         $error("FAIL resp_timeout: observed none expected resp at +%0d", e.lat);
         return;
      end
      check("latency", 32'(cyc - t), 32'(e.lat));
      check("resp_ok", 32'(resp_ok), 32'(e.ok));
      check("resp_src", 32'(resp_src), 32'(e.src));
      check("resp_strip_ID", 32'(resp_strip_ID), 32'(e.strip));
      check("wr_valid", 32'(wr_valid), 32'(e.ok));
      if (e.ok) begin
         check("strip_ID_out", 32'(strip_ID_out), 32'(e.strip));
         check("occupied_width_out", 32'(occupied_width_out), 32'(e.occ));
         check("strike_out", 32'(strike_out), 32'(e.strike));
      end
   endtask

   task automatic do_req(input bit src, input int w);
      int t;
      push_exp(src, w);
      if (src) begin req1_width = 8'(w); req1_valid = 1'b1; end
      else     begin req0_width = 8'(w); req0_valid = 1'b1; end
      wait_ready(src, t);
      wait_resp(t);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int t;
      int seen;
      rst = 1'b1; clr = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_width = 8'd0; req1_width = 8'd0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({req0_ready, req1_ready, wr_valid, strip_ID_out, occupied_width_out,
                 strike_out, resp_valid, resp_src, resp_ok, resp_strip_ID}), 32'd0);
      rst = 1'b0;

      // Basic placement then first-fit spill to strip 1
      do_req(0, 50);
      do_req(0, 60);
      do_req(0, 60);
      do_req(0, 60);

      // Simultaneous requests after requester 0 was last granted
      push_exp(1, 20);
      push_exp(0, 25);
      req0_width = 8'd25; req1_width = 8'd20;
      req0_valid = 1'b1;  req1_valid = 1'b1;
      wait_ready(1, t);
      check("rr_ready0_held", 32'(req0_ready), 32'd0);
      wait_resp(t);
      wait_ready(0, t);
      wait_resp(t);

      // Early rejects leave the table alone
      do_req(1, 0);
      do_req(0, 201);
      do_req(0, 30);

      // clr in IDLE empties the table
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_reset();
      do_req(0, 10);

      // Reset in the middle of a scan aborts the request
      apply_reset();
      for (int i = 0; i < 5; i++) do_req(0, 200);
      req0_width = 8'd200; req0_valid = 1'b1;
      wait_ready(0, t);
      while (cyc < t + 6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      seen = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (resp_valid !== 1'b0 || wr_valid !== 1'b0) seen++;
      end
      check("abort_no_resp", 32'(seen), 32'd0);
      do_req(0, 10);

      // Fill every strip, then drive strikes into saturation and retirement
      apply_reset();
      for (int i = 0; i < NS; i++) do_req(i[0], 200);
      for (int i = 0; i < 17; i++) do_req(0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/strip_alloc_ctrl.md
STRIP_ALLOC_CTRL -- requirements
Module: strip_alloc_ctrl

Interface
REQ-001 SHALL have parameter NUM_STRIPS, default 16, number of placement strips (strip ID 4 bits).
REQ-002 SHALL have parameter STRIP_WIDTH, default 200, capacity of each strip in width units (fits 8 bits).
REQ-003 SHALL have parameter STRIKE_LIMIT, default 15, strike count at which a strip is retired.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports req0_valid / req1_valid  input  1 each  placement request from requester 0 / 1.
REQ-007 SHALL have ports req0_width / req1_width  input  8 each  width the requester needs.
REQ-008 SHALL have ports req0_ready / req1_ready  output  1 each  request accepted this cycle.
REQ-009 SHALL have port clr  input  1  clear the occupancy and strike table.
REQ-010 SHALL have port wr_valid  output  1  write strobe toward the write/index pipeline register.
REQ-011 SHALL have ports strip_ID_out (4), occupied_width_out (8), strike_out (4)  output  updated entry of the selected strip.
REQ-012 SHALL have ports resp_valid (1), resp_src (1), resp_ok (1), resp_strip_ID (4)  output  placement result returned to the requester.

Function
REQ-013 SHALL hold one table per strip: occ[i] (8 bits) and strike[i] (4 bits).
REQ-014 SHALL implement an FSM with states IDLE, SCAN, WRITE and FAIL.
REQ-015 In IDLE, when at least one valid is high, SHALL grant exactly one requester, pulse its ready for that cycle, latch its width and source, clear the scan index to 0, and go to SCAN.
REQ-016 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted most recently wins; after reset, requester 0 wins.
REQ-017 If the latched width is 0 or greater than STRIP_WIDTH, SHALL go to FAIL instead of SCAN, with no table change.
REQ-018 SCAN SHALL examine one strip per cycle, at index idx.
REQ-019 In SCAN, a strip with strike[idx] == STRIKE_LIMIT is retired: skip it with no update.
REQ-020 In SCAN, fit is tested with a 9-bit sum: occ[idx] + width <= STRIP_WIDTH.
REQ-021 On fit: occ[idx] <= occ[idx] + width; the wr/resp output registers are loaded; go to WRITE.
REQ-022 On no fit: strike[idx] increments, saturating at STRIKE_LIMIT.
REQ-023 With no fit, idx == NUM_STRIPS-1 SHALL go to FAIL; otherwise idx increments.
REQ-024 WRITE SHALL last one cycle: wr_valid=1; strip_ID_out=idx; occupied_width_out=updated occ; strike_out=strike[idx]; resp_valid=1; resp_ok=1; resp_strip_ID=idx; resp_src=granted requester. The FSM then returns to IDLE.
REQ-025 FAIL SHALL last one cycle: resp_valid=1, resp_ok=0, resp_strip_ID=4'hF, wr_valid=0. The FSM then returns to IDLE.
REQ-026 Latency SHALL be as follows, where the accept cycle is T and k is the index of the first fitting strip:
- WRITE occurs in cycle T+2+k.
- A full failed scan gives FAIL in cycle T+1+NUM_STRIPS.
- An early reject (REQ-017) gives FAIL in cycle T+1.
REQ-027 No requester SHALL be accepted outside IDLE; ready is 0 in SCAN, WRITE and FAIL.
REQ-028 wr_valid, resp_valid, ready and all data outputs SHALL be registered, with no combinational path from input to output.
REQ-029 clr SHALL act only in IDLE: it zeroes all occ and strike, and no request is accepted that cycle. clr is ignored in other states.
REQ-030 Outside WRITE and FAIL, wr_valid and resp_valid SHALL be 0, and the data outputs hold their last values.

Reset
REQ-031 While rst=1 at a clock edge, the block SHALL:
- go to IDLE;
- clear idx, all occ, all strike and the round-robin pointer (requester 0 preferred);
- drive all outputs to 0.
REQ-032 rst mid-scan SHALL abort the request with no resp_valid and no wr_valid. Table updates made before reset are lost.

Verification
REQ-033 Reset, then req0_width=50 -> ready0 in T; WRITE in T+2; strip_ID_out=0, occupied_width_out=50, strike_out=0, resp_ok=1, resp_src=0.
REQ-034 Then three requests of width 60 -> strips 0, 0, 1 with occupied_width_out 110, 170, 60. The third request increments strike[0] to 1; its WRITE is 3 cycles after accept.
REQ-035 req0 and req1 valid in the same IDLE cycle, after requester 0 was last granted -> requester 1 is granted first, requester 0 next.
REQ-036 Width 0, and separately width 201 -> FAIL in T+1, resp_ok=0, resp_strip_ID=F, no table change.
REQ-037 Fill all 16 strips to 200, then request 1 repeatedly -> FAIL in T+17 each time. Every strike saturates at 15 and does not wrap. Once all strips are retired, a scan still takes 16 cycles and fails.
REQ-038 Assert rst during SCAN at idx=5 -> no resp_valid, table cleared. Then a clr-free request of 10 -> strip 0, occupied_width_out=10.
